fwrisc_mem_arbiter: RTL and testbench

Two-port to one-port memory arbiter that lets the FWRISC core's instruction-fetch port and data port share a single memory bus. It sits between the core and the single-ported memory or bus bridge. It grants one requester at a time, holds the grant until the memory completes the transfer, and routes the ready signal and read data back to the granted port. Fixed data-first priority is the default; round-robin is a build option.

---
 rtl/fwrisc_mem_arb_pkg.sv | 17 +
 rtl/fwrisc_mem_arb_sel.sv | 30 +++
 rtl/fwrisc_mem_arbiter.sv | 114 +++++++++++
 tb/tb_fwrisc_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwrisc_mem_arb_pkg.sv
// rtl/fwrisc_mem_arb_pkg.sv - shared types for the fetch/data memory arbiter
package fwrisc_mem_arb_pkg;

    localparam int ARB_STATE_W = 2;

    typedef enum logic [ARB_STATE_W-1:0] {
        ARB_IDLE = 2'd0,
        ARB_IBUS = 2'd1,
        ARB_DBUS = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } arb_port_e;

endpackage

// File: rtl/fwrisc_mem_arb_sel.sv
// rtl/fwrisc_mem_arb_sel.sv - grant pick between fetch and data requests
// FWRISC_MEM_ARB_RR_EN selects round-robin tie-break; otherwise data wins ties.
module fwrisc_mem_arb_sel
    import fwrisc_mem_arb_pkg::*;
(
    input  logic ivalid,
    input  logic dvalid,
    input  logic last_grant,
    output logic sel
);

`ifndef FWRISC_MEM_ARB_RR_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    always_comb begin
        sel = PORT_I;
        if (ivalid && dvalid) begin
`ifdef FWRISC_MEM_ARB_RR_EN
            sel = (last_grant == PORT_I) ? PORT_D : PORT_I;
`else
            sel = PORT_D;
`endif
        end else if (dvalid) begin
            sel = PORT_D;
        end
    end

endmodule

// File: rtl/fwrisc_mem_arbiter.sv
// rtl/fwrisc_mem_arbiter.sv - shares one memory bus between FWRISC fetch and data ports
// Build option FWRISC_MEM_ARB_RR_EN: round-robin tie-break instead of data-first.
module fwrisc_mem_arbiter
    import fwrisc_mem_arb_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [AWIDTH-1:0]   iaddr,
    input  logic                ivalid,
    output logic                iready,
    output logic [DWIDTH-1:0]   idata,
    input  logic [AWIDTH-1:0]   daddr,
    input  logic [DWIDTH-1:0]   dwdata,
    input  logic [DWIDTH/8-1:0] dwstb,
    input  logic                dwrite,
    input  logic                dvalid,
    output logic                dready,
    output logic [DWIDTH-1:0]   drdata,
    output logic [AWIDTH-1:0]   maddr,
    output logic [DWIDTH-1:0]   mwdata,
    output logic [DWIDTH/8-1:0] mwstb,
    output logic                mwrite,
    output logic                mvalid,
    input  logic [DWIDTH-1:0]   mrdata,
    input  logic                mready,
    output logic                gnt_d
);

    arb_state_e state_q, state_d;
    arb_port_e  last_grant_q, last_grant_d;
    logic       sel;

    fwrisc_mem_arb_sel u_sel (
        .ivalid     (ivalid),
        .dvalid     (dvalid),
        .last_grant (last_grant_q),
        .sel        (sel)
    );

    assign idata  = mrdata;
    assign drdata = mrdata;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= PORT_I;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // A granted port dropping valid early abandons the transfer without touching last_grant.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ARB_IDLE: begin
                if (ivalid || dvalid) begin
                    state_d = (sel == PORT_D) ? ARB_DBUS : ARB_IBUS;
                end
            end
            ARB_IBUS: begin
                if (!ivalid) begin
                    state_d = ARB_IDLE;
                end else if (mready) begin
                    state_d      = ARB_IDLE;
                    last_grant_d = PORT_I;
                end
            end
            ARB_DBUS: begin
                if (!dvalid) begin
                    state_d = ARB_IDLE;
                end else if (mready) begin
                    state_d      = ARB_IDLE;
                    last_grant_d = PORT_D;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        mvalid = 1'b0;
        maddr  = '0;
        mwdata = '0;
        mwstb  = '0;
        mwrite = 1'b0;
        iready = 1'b0;
        dready = 1'b0;
        gnt_d  = 1'b0;
        case (state_q)
            ARB_IBUS: begin
                mvalid = ivalid;
                maddr  = iaddr;
                iready = ivalid && mready;
            end
            ARB_DBUS: begin
                mvalid = dvalid;
                maddr  = daddr;
                mwdata = dwdata;
                mwstb  = dwstb;
                mwrite = dwrite;
                dready = dvalid && mready;
                gnt_d  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fwrisc_mem_arbiter.sv
// tb/tb_fwrisc_mem_arbiter.sv - randomized and directed bench for fwrisc_mem_arbiter
module tb_fwrisc_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] iaddr = '0;
    logic          ivalid = 1'b0;
    logic          iready;
    logic [DW-1:0] idata;
    logic [AW-1:0] daddr = '0;
    logic [DW-1:0] dwdata = '0;
    logic [SW-1:0] dwstb = '0;
    logic          dwrite = 1'b0;
    logic          dvalid = 1'b0;
    logic          dready;
    logic [DW-1:0] drdata;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwdata;
    logic [SW-1:0] mwstb;
    logic          mwrite;
    logic          mvalid;
    logic [DW-1:0] mrdata = '0;
    logic          mready = 1'b0;
    logic          gnt_d;

    fwrisc_mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clock(clock), .reset(reset),
        .iaddr(iaddr), .ivalid(ivalid), .iready(iready), .idata(idata),
        .daddr(daddr), .dwdata(dwdata), .dwstb(dwstb), .dwrite(dwrite),
        .dvalid(dvalid), .dready(dready), .drdata(drdata),
        .maddr(maddr), .mwdata(mwdata), .mwstb(mwstb), .mwrite(mwrite),
        .mvalid(mvalid), .mrdata(mrdata), .mready(mready), .gnt_d(gnt_d)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: who owns the bus (0 none, 1 fetch, 2 data) and who was served last.
    int owner = 0;
    int last  = 1;

    function automatic int tie_winner(input int last_served);
`ifdef FWRISC_MEM_ARB_RR_EN
        return (last_served == 1) ? 2 : 1;
`else
        return 2;
`endif
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner = 0;
            last  = 1;
        end else if (owner == 0) begin
            if (ivalid && dvalid) owner = tie_winner(last);
            else if (dvalid)      owner = 2;
            else if (ivalid)      owner = 1;
        end else if (owner == 1) begin
            if (!ivalid) owner = 0;
            else if (mready) begin owner = 0; last = 1; end
        end else begin
            if (!dvalid) owner = 0;
            else if (mready) begin owner = 0; last = 2; end
        end
    end

    always @(negedge clock) begin
        #2;
        if (reset) begin
            check("m_mvalid", mvalid, owner == 1 ? ivalid : owner == 2 ? dvalid : 1'b0);
            check("m_maddr", maddr, owner == 1 ? iaddr : owner == 2 ? daddr : '0);
            if (owner != 1) check("m_mwdata", mwdata, owner == 2 ? dwdata : '0);
            check("m_mwstb", mwstb, owner == 2 ? dwstb : '0);
            check("m_mwrite", mwrite, owner == 2 ? dwrite : 1'b0);
            check("m_iready", iready, owner == 1 && ivalid && mready);
            check("m_dready", dready, owner == 2 && dvalid && mready);
            check("m_gnt_d", gnt_d, owner == 2);
            check("m_idata", idata, mrdata);
            check("m_drdata", drdata, mrdata);
        end
    end

    logic i_fire = 1'b0;
    logic d_fire = 1'b0;
    int   act_q[$];
    int   n_ireq = 0, n_idone = 0, n_dreq = 0, n_ddone = 0;

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic sample_fires();
        i_fire = ivalid && iready;
        d_fire = dvalid && dready;
        if (d_fire) act_q.push_back(2);
        if (i_fire) act_q.push_back(1);
    endtask

    // Both requesters keep asking, resting one cycle after each completion.
    task automatic run_reqs(input string tag, input int want, input int maxc);
        for (int c = 0; c < maxc && act_q.size() < want; c++) begin
            cyc();
            ivalid = !i_fire;
            dvalid = !d_fire;
            iaddr  = 32'h1000 + c;
            daddr  = 32'h2000 + c;
            #1 sample_fires();
        end
        check(tag, act_q.size(), want);
        cyc();
        ivalid = 1'b0; dvalid = 1'b0; i_fire = 1'b0; d_fire = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        // reset holds everything quiet even with requests present
        ivalid = 1'b1; dvalid = 1'b1; mready = 1'b1; iaddr = 32'h44; daddr = 32'h88;
        repeat (3) cyc();
        #1;
        check("rst_mvalid", mvalid, 1'b0);
        check("rst_maddr", maddr, '0);
        check("rst_ready", {iready, dready}, 2'b00);
        check("rst_gnt_d", gnt_d, 1'b0);
        ivalid = 1'b0; dvalid = 1'b0; mready = 1'b0;
        cyc(); reset = 1'b1;

        // single fetch
        cyc(); ivalid = 1'b1; iaddr = 32'h100; mready = 1'b1; mrdata = 32'hDEADBEEF;
        #1 check("f_idle_mvalid", mvalid, 1'b0);
        cyc(); #1;
        check("f_mvalid", mvalid, 1'b1);
        check("f_maddr", maddr, 32'h100);
        check("f_iready", iready, 1'b1);
        check("f_idata", idata, 32'hDEADBEEF);
        check("f_dready", dready, 1'b0);
        cyc(); ivalid = 1'b0; #1;
        check("f_iready_once", iready, 1'b0);

        // single write
        cyc(); dvalid = 1'b1; daddr = 32'h2000; dwdata = 32'h12345678; dwstb = 4'hF; dwrite = 1'b1;
        cyc(); #1;
        check("w_mwrite", mwrite, 1'b1);
        check("w_mwstb", mwstb, 4'hF);
        check("w_mwdata", mwdata, 32'h12345678);
        check("w_maddr", maddr, 32'h2000);
        check("w_gnt_d", gnt_d, 1'b1);
        check("w_dready", dready, 1'b1);
        cyc(); dvalid = 1'b0; dwrite = 1'b0; #1;
        check("w_gnt_d_off", gnt_d, 1'b0);

        // simultaneous requests: D, I, D
        act_q.delete();
        run_reqs("tie_count", 3, 20);
        if (act_q.size() >= 3) begin
            check("tie_1st", act_q[0], 2);
            check("tie_2nd", act_q[1], 1);
            check("tie_3rd", act_q[2], 2);
        end

        // memory wait states
        cyc(); dvalid = 1'b1; daddr = 32'h3000; dwrite = 1'b0; mready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc(); #1;
            check("ws_mvalid", mvalid, 1'b1);
            check("ws_maddr", maddr, 32'h3000);
            check("ws_dready", dready, 1'b0);
        end
        cyc(); mready = 1'b1; #1;
        check("ws_dready_hit", dready, 1'b1);
        cyc(); dvalid = 1'b0; mready = 1'b0; #1;
        check("ws_dready_once", dready, 1'b0);

        // reset during a data transfer
        cyc(); dvalid = 1'b1; daddr = 32'h4000; mready = 1'b0;
        cyc(); #1 check("rm_gnt_before", gnt_d, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("rm_mvalid", mvalid, 1'b0);
        check("rm_dready", dready, 1'b0);
        check("rm_gnt_d", gnt_d, 1'b0);
        cyc(); ivalid = 1'b1; dvalid = 1'b1; mready = 1'b1;
        #1 reset = 1'b1;
        act_q.delete();
        run_reqs("rm_count", 1, 10);
        if (act_q.size() >= 1) check("rm_first_tie", act_q[0], 2);

        // fetch drops valid while granted; pending data request goes next
        cyc(); ivalid = 1'b1; iaddr = 32'h5000; mready = 1'b0;
        cyc(); #1;
        check("pv_mvalid", mvalid, 1'b1);
        check("pv_gnt_d", gnt_d, 1'b0);
        cyc(); ivalid = 1'b0; dvalid = 1'b1; daddr = 32'h6000; dwrite = 1'b0; #1;
        check("pv_mvalid_drop", mvalid, 1'b0);
        check("pv_iready", iready, 1'b0);
        cyc(); #1 check("pv_idle", {mvalid, gnt_d}, 2'b00);
        cyc(); mready = 1'b1; #1;
        check("pv_d_gnt", gnt_d, 1'b1);
        check("pv_d_addr", maddr, 32'h6000);
        check("pv_dready", dready, 1'b1);
        cyc(); dvalid = 1'b0; mready = 1'b0;

        // randomized traffic against the reference model
        i_fire = 1'b0; d_fire = 1'b0;
        for (int c = 0; c < 600; c++) begin
            cyc();
            if (!ivalid || i_fire) begin
                ivalid = ($urandom_range(0, 2) == 0);
                iaddr  = $urandom;
                if (ivalid) n_ireq++;
            end
            if (!dvalid || d_fire) begin
                dvalid = ($urandom_range(0, 2) == 0);
                daddr  = $urandom;
                dwdata = $urandom;
                dwstb  = 4'($urandom_range(0, 15));
                dwrite = 1'($urandom_range(0, 1));
                if (dvalid) n_dreq++;
            end
            mready = 1'($urandom_range(0, 1));
            mrdata = $urandom;
            #1 sample_fires();
            if (i_fire) n_idone++;
            if (d_fire) n_ddone++;
        end
        mready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (i_fire) ivalid = 1'b0;
            if (d_fire) dvalid = 1'b0;
            #1 sample_fires();
            if (i_fire) n_idone++;
            if (d_fire) n_ddone++;
        end
        check("rand_i_served", n_idone, n_ireq);
        check("rand_d_served", n_ddone, n_dreq);

        cyc();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
